// File: rtl/instr_fetch.sv
// instr_fetch: fetch-side initiator for the instruction memory read port.
// Issues word-aligned reads, captures the returned word(s) into a small
// {pc, instr} FIFO and presents the FIFO head to decode over valid/ready.
// A redirect flushes both queued entries and any response still in flight.
// Build option: define PRED_PAIR_EN to take two words per read
// (mem_rdata at fetch_pc, mem_rdata_pred at fetch_pc+4); otherwise one word.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] mem_addr,
   output logic        mem_renable,
   input  logic [31:0] mem_rdata,
   input  logic [31:0] mem_rdata_pred,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc
);

`ifdef PRED_PAIR_EN
   localparam int unsigned W = 2;
`else
   localparam int unsigned W = 1;
`endif
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [31:0]   STEP    = 32'(4 * W);
   localparam logic [CW-1:0] W_CNT   = CW'(W);
   localparam logic [CW-1:0] ONE_CNT = CW'(1);
   localparam logic [CW-1:0] ZERO_CNT = CW'(0);
   localparam logic [CW-1:0] LIMIT   = CW'(DEPTH - W);
   localparam logic [AW-1:0] ONE_PTR = AW'(1);
   localparam logic [AW-1:0] W_PTR   = AW'(W);
   localparam logic [AW-1:0] ZERO_PTR = AW'(0);

   logic [31:0]   fetch_pc;
   logic          pending;
   logic [CW-1:0] count;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [31:0]   pc_store    [DEPTH];
   logic [31:0]   instr_store [DEPTH];

   logic [CW-1:0] credit;
   logic [CW-1:0] push_cnt;
   logic [CW-1:0] pop_cnt;
   logic          issue;
   logic          push;
   logic          pop;
   logic [31:0]   resp_pc;

`ifdef PRED_PAIR_EN
   logic unused_bits;
   assign unused_bits = ^redirect_pc[1:0];
`else
   logic unused_bits;
   assign unused_bits = ^{mem_rdata_pred, redirect_pc[1:0]};
`endif

   // Per-cycle issue / push / pop decisions; in-flight words are reserved
   // against FIFO space, same-cycle pops are not credited.
   always_comb begin
      credit   = count;
      issue    = 1'b0;
      push     = 1'b0;
      pop      = 1'b0;
      push_cnt = ZERO_CNT;
      pop_cnt  = ZERO_CNT;
      // The only outstanding read was issued from fetch_pc before its advance.
      resp_pc  = fetch_pc - STEP;
      if (pending) begin
         credit = count + W_CNT;
      end else begin
         credit = count;
      end
      if (rst || redirect_valid) begin
         issue = 1'b0;
         push  = 1'b0;
      end else begin
         issue = (credit <= LIMIT);
         push  = pending;
      end
      pop = (count != ZERO_CNT) && if_ready;
      if (push) begin
         push_cnt = W_CNT;
      end else begin
         push_cnt = ZERO_CNT;
      end
      if (pop) begin
         pop_cnt = ONE_CNT;
      end else begin
         pop_cnt = ZERO_CNT;
      end
   end

   // Fetch PC, in-flight flag and FIFO bookkeeping; redirect flushes everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= {RESET_PC[31:2], 2'b00};
         pending  <= 1'b0;
         count    <= ZERO_CNT;
         rd_ptr   <= ZERO_PTR;
         wr_ptr   <= ZERO_PTR;
      end else if (redirect_valid) begin
         fetch_pc <= {redirect_pc[31:2], 2'b00};
         pending  <= 1'b0;
         count    <= ZERO_CNT;
         rd_ptr   <= ZERO_PTR;
         wr_ptr   <= ZERO_PTR;
      end else begin
         if (issue) begin
            fetch_pc <= fetch_pc + STEP;
         end
         pending <= issue;
         count   <= count + push_cnt - pop_cnt;
         if (push) begin
            wr_ptr <= wr_ptr + W_PTR;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ONE_PTR;
         end
      end
   end

   // FIFO storage; entries are only meaningful while counted, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_store[wr_ptr] <= mem_rdata;
         pc_store[wr_ptr]    <= resp_pc;
`ifdef PRED_PAIR_EN
         instr_store[wr_ptr + ONE_PTR] <= mem_rdata_pred;
         pc_store[wr_ptr + ONE_PTR]    <= resp_pc + 32'd4;
`endif
      end
   end

   assign mem_addr    = {fetch_pc[31:2], 2'b00};
   assign mem_renable = issue;
   assign if_valid    = (count != ZERO_CNT);
   assign if_instr    = if_valid ? instr_store[rd_ptr] : 32'h0000_0000;
   assign if_pc       = if_valid ? pc_store[rd_ptr]    : 32'h0000_0000;

endmodule
